// File: rtl/alu_rs2_stage_if.sv
// alu_rs2_stage_if: bundle of the operand-B stage handshake and data signals.
// The upstream/testbench side uses the master modport, the stage uses slave.
// When ALU_RS2_FWD_EN is defined, the writeback forwarding signals are added.
interface alu_rs2_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             io_in_valid;
   logic             io_in_ready;
   logic [XLEN-1:0]  io_pc;
   logic [XLEN-1:0]  io_imm_s;
   logic [XLEN-1:0]  io_imm_i;
   logic [XLEN-1:0]  io_imm_u;
   logic [XLEN-1:0]  io_rs2;
   logic [4:0]       io_rs2_addr;
   logic [2:0]       io_rs2_mux_sel;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [XLEN-1:0]  io_to_alu_b;
   logic             io_sel_err;
   logic [CNT_W-1:0] io_stall_cnt;
`ifdef ALU_RS2_FWD_EN
   logic             io_wb_valid;
   logic [4:0]       io_wb_addr;
   logic [XLEN-1:0]  io_wb_data;
`endif

   modport master (
`ifdef ALU_RS2_FWD_EN
      output io_wb_valid, io_wb_addr, io_wb_data,
`endif
      output io_in_valid, io_pc, io_imm_s, io_imm_i, io_imm_u, io_rs2,
      output io_rs2_addr, io_rs2_mux_sel, io_out_ready,
      input  io_in_ready, io_out_valid, io_to_alu_b, io_sel_err, io_stall_cnt
   );

   modport slave (
`ifdef ALU_RS2_FWD_EN
      input  io_wb_valid, io_wb_addr, io_wb_data,
`endif
      input  io_in_valid, io_pc, io_imm_s, io_imm_i, io_imm_u, io_rs2,
      input  io_rs2_addr, io_rs2_mux_sel, io_out_ready,
      output io_in_ready, io_out_valid, io_to_alu_b, io_sel_err, io_stall_cnt
   );
endinterface

// File: rtl/alu_rs2_stage.sv
// alu_rs2_stage: registered ALU operand-B select with a 2-entry elastic buffer
// (output register + skid register), valid/ready on both sides, illegal-select
// flag travelling with the data and a saturating output-stall counter.
// in_ready is a flop, so downstream back-pressure never reaches upstream
// combinationally.
// Optional macro ALU_RS2_FWD_EN: writeback forwarding into captured and held
// rs2 entries (adds io_wb_valid / io_wb_addr / io_wb_data to the interface).
module alu_rs2_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic           clock,
   input  logic           reset,
   alu_rs2_stage_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // Returns {sel_err, data}; selects 6 and 7 are illegal and yield zero data.
   function automatic logic [XLEN:0] select_operand(
      input logic [2:0]      sel,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] imm_s,
      input logic [XLEN-1:0] imm_i,
      input logic [XLEN-1:0] rs2,
      input logic [XLEN-1:0] imm_u
   );
      logic [XLEN:0] res;
      res = {1'b1, {XLEN{1'b0}}};
      case (sel)
         3'd0:    res = {1'b0, pc};
         3'd1:    res = {1'b0, imm_s};
         3'd2:    res = {1'b0, imm_i};
         3'd3:    res = {1'b0, rs2};
         3'd4:    res = {1'b0, imm_u};
         3'd5:    res = {1'b0, {(XLEN-3){1'b0}}, 3'b100};
         default: res = {1'b1, {XLEN{1'b0}}};
      endcase
      return res;
   endfunction

`ifdef ALU_RS2_FWD_EN
   // A writeback to x0 never forwards; otherwise match on register index.
   function automatic logic fwd_hit(
      input logic       wb_valid,
      input logic [4:0] wb_addr,
      input logic [4:0] entry_addr
   );
      return wb_valid && (wb_addr != 5'd0) && (wb_addr == entry_addr);
   endfunction
`endif

   state_t            state_r;
   state_t            state_nx_s;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              accept_s;
   logic              load_out_new_s;
   logic              load_out_skid_s;
   logic              load_skid_new_s;

   logic [XLEN:0]     sel_res_s;
   logic [XLEN-1:0]   new_data_s;
   logic              new_err_s;
   logic              new_is_rs2_s;

   logic [XLEN-1:0]   out_data_r;
   logic              out_err_r;
   logic              out_is_rs2_r;
   logic [4:0]        out_addr_r;
   logic [XLEN-1:0]   out_hold_data_s;

   logic [XLEN-1:0]   skid_data_r;
   logic              skid_err_r;
   logic              skid_is_rs2_r;
   logic [4:0]        skid_addr_r;
   logic [XLEN-1:0]   skid_hold_data_s;

   logic [CNT_W-1:0]  stall_cnt_r;
   logic              stall_inc_s;

   assign accept_s    = bus.io_in_valid & in_ready_r;
   assign stall_inc_s = out_valid_r & ~bus.io_out_ready;

   // Build the incoming entry; a forwarded writeback overrides captured rs2.
   always_comb begin
      sel_res_s    = select_operand(bus.io_rs2_mux_sel, bus.io_pc, bus.io_imm_s,
                                    bus.io_imm_i, bus.io_rs2, bus.io_imm_u);
      new_err_s    = sel_res_s[XLEN];
      new_is_rs2_s = (bus.io_rs2_mux_sel == 3'd3);
`ifdef ALU_RS2_FWD_EN
      if (new_is_rs2_s && fwd_hit(bus.io_wb_valid, bus.io_wb_addr, bus.io_rs2_addr)) begin
         new_data_s = bus.io_wb_data;
      end else begin
         new_data_s = sel_res_s[XLEN-1:0];
      end
`else
      new_data_s = sel_res_s[XLEN-1:0];
`endif
   end

   // Held-entry data as it should look next cycle (newest writeback wins).
   always_comb begin
`ifdef ALU_RS2_FWD_EN
      if (out_is_rs2_r && fwd_hit(bus.io_wb_valid, bus.io_wb_addr, out_addr_r)) begin
         out_hold_data_s = bus.io_wb_data;
      end else begin
         out_hold_data_s = out_data_r;
      end
      if (skid_is_rs2_r && fwd_hit(bus.io_wb_valid, bus.io_wb_addr, skid_addr_r)) begin
         skid_hold_data_s = bus.io_wb_data;
      end else begin
         skid_hold_data_s = skid_data_r;
      end
`else
      out_hold_data_s  = out_data_r;
      skid_hold_data_s = skid_data_r;
`endif
   end

`ifndef ALU_RS2_FWD_EN
   // Entry metadata only steers forwarding; without it nothing reads these.
   logic unused_meta_s;
   assign unused_meta_s = ^{out_is_rs2_r, out_addr_r, skid_is_rs2_r, skid_addr_r};
`endif

   // Next-state and buffer load decisions for the two-entry elastic buffer.
   always_comb begin
      state_nx_s      = state_r;
      load_out_new_s  = 1'b0;
      load_out_skid_s = 1'b0;
      load_skid_new_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               load_out_new_s = 1'b1;
               state_nx_s     = ST_ONE;
            end else begin
               state_nx_s     = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && bus.io_out_ready) begin
               load_out_new_s  = 1'b1;
               state_nx_s      = ST_ONE;
            end else if (accept_s) begin
               load_skid_new_s = 1'b1;
               state_nx_s      = ST_TWO;
            end else if (bus.io_out_ready) begin
               state_nx_s      = ST_EMPTY;
            end else begin
               state_nx_s      = ST_ONE;
            end
         end
         ST_TWO: begin
            if (bus.io_out_ready) begin
               load_out_skid_s = 1'b1;
               state_nx_s      = ST_ONE;
            end else begin
               state_nx_s      = ST_TWO;
            end
         end
         default: begin
            state_nx_s = ST_EMPTY;
         end
      endcase
   end

   // State register plus handshake flags registered from the next state.
   always_ff @(posedge clock) begin
      if (reset == 1'b0) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s != ST_TWO);
         out_valid_r <= (state_nx_s != ST_EMPTY);
      end
   end

   // Output register: take the new entry, promote the skid entry, or hold.
   always_ff @(posedge clock) begin
      if (reset == 1'b0) begin
         out_data_r   <= {XLEN{1'b0}};
         out_err_r    <= 1'b0;
         out_is_rs2_r <= 1'b0;
         out_addr_r   <= 5'd0;
      end else if (load_out_new_s) begin
         out_data_r   <= new_data_s;
         out_err_r    <= new_err_s;
         out_is_rs2_r <= new_is_rs2_s;
         out_addr_r   <= bus.io_rs2_addr;
      end else if (load_out_skid_s) begin
         out_data_r   <= skid_hold_data_s;
         out_err_r    <= skid_err_r;
         out_is_rs2_r <= skid_is_rs2_r;
         out_addr_r   <= skid_addr_r;
      end else begin
         out_data_r   <= out_hold_data_s;
      end
   end

   // Skid register: captures the entry accepted while the output is blocked.
   always_ff @(posedge clock) begin
      if (reset == 1'b0) begin
         skid_data_r   <= {XLEN{1'b0}};
         skid_err_r    <= 1'b0;
         skid_is_rs2_r <= 1'b0;
         skid_addr_r   <= 5'd0;
      end else if (load_skid_new_s) begin
         skid_data_r   <= new_data_s;
         skid_err_r    <= new_err_s;
         skid_is_rs2_r <= new_is_rs2_s;
         skid_addr_r   <= bus.io_rs2_addr;
      end else begin
         skid_data_r   <= skid_hold_data_s;
      end
   end

   // Saturating count of cycles where valid output data is not consumed.
   always_ff @(posedge clock) begin
      if (reset == 1'b0) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.io_in_ready  = in_ready_r;
   assign bus.io_out_valid = out_valid_r;
   assign bus.io_to_alu_b  = out_data_r;
   assign bus.io_sel_err   = out_err_r;
   assign bus.io_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_alu_rs2_stage.sv
// tb_alu_rs2_stage: directed + randomized bench for alu_rs2_stage.
// Reference model is a bounded FIFO (capacity 2) of expected entries.
module tb_alu_rs2_stage;
   localparam int XLEN      = 32;
   localparam int CNT_W     = 4;
   localparam int STALL_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        is_rs2;
      logic [4:0]  addr;
   } ent_t;

   logic clock;
   logic reset;

   alu_rs2_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   alu_rs2_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int    n_checks = 0;
   int    n_pass   = 0;
   ent_t  mq[$];
   int    m_stall  = 0;
   bit    m_acc    = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit fwd_hit_m(input logic [4:0] a);
`ifdef ALU_RS2_FWD_EN
      return bus.io_wb_valid === 1'b1 && bus.io_wb_addr != 5'd0 && bus.io_wb_addr == a;
`else
      return 1'b0;
`endif
   endfunction

   // Advance the reference model by one clock edge using the driven inputs.
   task automatic model_step();
      ent_t        e;
      logic [31:0] ops [6];
      if (reset == 1'b0) begin
         mq.delete();
         m_stall = 0;
         m_acc   = 1'b0;
      end else begin
         m_acc = bus.io_in_valid && (mq.size() < 2);
         if (mq.size() > 0 && !bus.io_out_ready && m_stall < STALL_MAX) m_stall++;
         if (mq.size() > 0 && bus.io_out_ready) void'(mq.pop_front());
`ifdef ALU_RS2_FWD_EN
         foreach (mq[k]) begin
            if (mq[k].is_rs2 && fwd_hit_m(mq[k].addr)) mq[k].data = bus.io_wb_data;
         end
`endif
         if (m_acc) begin
            ops = '{bus.io_pc, bus.io_imm_s, bus.io_imm_i, bus.io_rs2, bus.io_imm_u, 32'd4};
            if (bus.io_rs2_mux_sel < 3'd6) begin
               e.data = ops[bus.io_rs2_mux_sel];
               e.err  = 1'b0;
            end else begin
               e.data = 32'd0;
               e.err  = 1'b1;
            end
            e.is_rs2 = (bus.io_rs2_mux_sel == 3'd3);
            e.addr   = bus.io_rs2_addr;
`ifdef ALU_RS2_FWD_EN
            if (e.is_rs2 && fwd_hit_m(e.addr)) e.data = bus.io_wb_data;
`endif
            mq.push_back(e);
         end
      end
   endtask

   task automatic compare_all();
      chk("in_ready", bus.io_in_ready, mq.size() < 2);
      chk("out_valid", bus.io_out_valid, mq.size() > 0);
      chk("stall_cnt", bus.io_stall_cnt, m_stall);
      if (mq.size() > 0) begin
         chk("to_alu_b", bus.io_to_alu_b, mq[0].data);
         chk("sel_err", bus.io_sel_err, mq[0].err);
      end
   endtask

   // One clock: update model for the coming edge, then compare after it.
   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic rand_ops();
      bus.io_pc          = $urandom;
      bus.io_imm_s       = $urandom;
      bus.io_imm_i       = $urandom;
      bus.io_imm_u       = $urandom;
      bus.io_rs2         = $urandom;
      bus.io_rs2_addr    = 5'($urandom_range(0, 7));
      bus.io_rs2_mux_sel = 3'($urandom_range(0, 7));
   endtask

   logic [31:0] seen[$];
   logic [31:0] sweep_exp [8];
   logic [31:0] bp_vals [3];
   bit          c_acc;

   initial begin
      reset           = 1'b0;
      bus.io_in_valid = 1'b1;
      bus.io_out_ready = 1'b1;
`ifdef ALU_RS2_FWD_EN
      bus.io_wb_valid = 1'b0;
      bus.io_wb_addr  = 5'd0;
      bus.io_wb_data  = 32'd0;
`endif
      rand_ops();

      // Reset held 2 cycles with in_valid=1: nothing accepted.
      tick();
      tick();
      chk("rst_to_alu_b", bus.io_to_alu_b, 32'd0);
      chk("rst_sel_err", bus.io_sel_err, 1'b0);
      reset           = 1'b1;
      bus.io_in_valid = 1'b0;
      tick();
      chk("rst_rel_out_valid", bus.io_out_valid, 1'b0);
      chk("rst_rel_to_alu_b", bus.io_to_alu_b, 32'd0);

      // Select sweep at full throughput.
      sweep_exp = '{32'h100, 32'hFFFF_FFF0, 32'h7FF, 32'hDEAD_BEEF,
                    32'h1234_5000, 32'h4, 32'h0, 32'h0};
      bus.io_pc = 32'h100; bus.io_imm_s = 32'hFFFF_FFF0; bus.io_imm_i = 32'h7FF;
      bus.io_rs2 = 32'hDEAD_BEEF; bus.io_imm_u = 32'h1234_5000; bus.io_rs2_addr = 5'd0;
      for (int i = 0; i < 8; i++) begin
         bus.io_in_valid    = 1'b1;
         bus.io_rs2_mux_sel = 3'(i);
         tick();
         chk("sweep_valid", bus.io_out_valid, 1'b1);
         chk("sweep_data", bus.io_to_alu_b, sweep_exp[i]);
         chk("sweep_err", bus.io_sel_err, (i >= 6) ? 1'b1 : 1'b0);
      end

      // Back-pressure: A into output, B into skid, C refused.
      bus.io_in_valid = 1'b0;
      tick();
      tick();
      bp_vals = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      bus.io_out_ready   = 1'b0;
      bus.io_in_valid    = 1'b1;
      bus.io_rs2_mux_sel = 3'd3;
      for (int i = 0; i < 3; i++) begin
         bus.io_rs2 = bp_vals[i];
         tick();
      end
      chk("bp_out_a", bus.io_to_alu_b, bp_vals[0]);
      chk("bp_in_ready", bus.io_in_ready, 1'b0);
      chk("bp_stall", bus.io_stall_cnt, 4'd2);
      bus.io_out_ready = 1'b1;
      c_acc = 1'b0;
      for (int i = 0; i < 8 && !c_acc; i++) begin
         if (bus.io_out_valid && bus.io_out_ready) seen.push_back(bus.io_to_alu_b);
         tick();
         c_acc = m_acc;
      end
      chk("bp_c_accepted", c_acc, 1'b1);
      bus.io_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.io_out_valid && bus.io_out_ready) seen.push_back(bus.io_to_alu_b);
         tick();
      end
      chk("bp_count", seen.size(), 3);
      for (int i = 0; i < 3 && i < seen.size(); i++) chk("bp_order", seen[i], bp_vals[i]);
      chk("bp_stall_final", bus.io_stall_cnt, 4'd2);

      // Mid-operation reset from the two-entry state.
      bus.io_out_ready = 1'b0;
      bus.io_in_valid  = 1'b1;
      bus.io_rs2 = 32'h1111_1111; tick();
      bus.io_rs2 = 32'h2222_2222; tick();
      chk("mid_two_in_ready", bus.io_in_ready, 1'b0);
      reset = 1'b0;
      tick();
      chk("mid_rst_out_valid", bus.io_out_valid, 1'b0);
      chk("mid_rst_in_ready", bus.io_in_ready, 1'b1);
      chk("mid_rst_to_alu_b", bus.io_to_alu_b, 32'd0);
      reset            = 1'b1;
      bus.io_in_valid  = 1'b0;
      bus.io_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_no_ghost", bus.io_out_valid, 1'b0);
      end

      // Stall counter saturation.
      bus.io_out_ready = 1'b0;
      bus.io_in_valid  = 1'b1;
      tick();
      bus.io_in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", bus.io_stall_cnt, 4'd15);
      bus.io_out_ready = 1'b1;
      tick();
      chk("sat_hold", bus.io_stall_cnt, 4'd15);

`ifdef ALU_RS2_FWD_EN
      // Forward at accept.
      bus.io_in_valid = 1'b1; bus.io_rs2_mux_sel = 3'd3; bus.io_rs2_addr = 5'd5;
      bus.io_rs2 = 32'h1; bus.io_wb_valid = 1'b1; bus.io_wb_addr = 5'd5; bus.io_wb_data = 32'h22;
      tick();
      chk("fwd_accept", bus.io_to_alu_b, 32'h22);
      // Forward into a stalled entry.
      bus.io_out_ready = 1'b0; bus.io_wb_valid = 1'b0;
      bus.io_rs2_addr = 5'd7; bus.io_rs2 = 32'h10;
      tick();
      tick();
      bus.io_in_valid = 1'b0;
      tick();
      chk("fwd_held_before", bus.io_to_alu_b, 32'h22);
      bus.io_out_ready = 1'b1;
      tick();
      chk("fwd_held_pre", bus.io_to_alu_b, 32'h10);
      bus.io_out_ready = 1'b0;
      bus.io_wb_valid = 1'b1; bus.io_wb_addr = 5'd7; bus.io_wb_data = 32'h33;
      tick();
      chk("fwd_held", bus.io_to_alu_b, 32'h33);
      bus.io_out_ready = 1'b1; bus.io_wb_valid = 1'b0;
      tick();
      tick();
      // x0 never forwards.
      bus.io_in_valid = 1'b1; bus.io_rs2_addr = 5'd0; bus.io_rs2 = 32'h55;
      bus.io_wb_valid = 1'b1; bus.io_wb_addr = 5'd0; bus.io_wb_data = 32'h66;
      tick();
      chk("fwd_x0", bus.io_to_alu_b, 32'h55);
      bus.io_in_valid = 1'b0; bus.io_wb_valid = 1'b0;
      tick();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset            = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         bus.io_in_valid  = 1'($urandom_range(0, 1));
         bus.io_out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         rand_ops();
`ifdef ALU_RS2_FWD_EN
         bus.io_wb_valid = 1'($urandom_range(0, 1));
         bus.io_wb_addr  = 5'($urandom_range(0, 7));
         bus.io_wb_data  = $urandom;
`endif
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
